// File: rtl/byte_bus_receiver.sv
// Byte bus receiver: captures registered switch bytes into a small FIFO.
// Optional: BYTE_BUS_RECEIVER_ZERO_DROP_EN discards all-zero bytes.
module byte_bus_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bus_en,
  input  logic [WIDTH-1:0]           bus_data,
  input  logic                       rd_en,
  input  logic                       clr_ovf,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             en_d;
  logic             push;
  logic             pop;
  logic             wr;
  logic             drop;
  logic [CW-1:0]    count_nx;

  always_comb begin
    push = en_d;
`ifdef BYTE_BUS_RECEIVER_ZERO_DROP_EN
    push = en_d && (bus_data != '0);
`endif
    pop  = rd_en && !empty;
    // a pop frees the slot the push needs when full
    wr   = push && (!full || pop);
    drop = push && full && !pop;
    count_nx = count;
    if (wr && !pop)
      count_nx = count + CW'(1);
    else if (pop && !wr)
      count_nx = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_d     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      en_d     <= bus_en;
      rd_valid <= pop;
      count    <= count_nx;
      empty    <= (count_nx == '0);
      full     <= (count_nx == CW'(DEPTH));
      if (wr)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= mem[rd_ptr];
      end
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= bus_data;
  end

endmodule
